// File: rtl/sync_filter_bank.sv
// sync_filter_bank: N-channel synchroniser bank with per-channel deglitch filter and edge pulses
//   clk_i    : single clock, all flops rising-edge
//   rst_i    : synchronous reset, active-high
//   idata_i  : asynchronous level inputs, one per channel
//   odata_o  : synchronised, filtered levels (registered)
//   rise_o   : 1-cycle pulse coincident with odata_o[i] 0->1 (registered)
//   fall_o   : 1-cycle pulse coincident with odata_o[i] 1->0 (registered)
//   chg_o    : any rise_o/fall_o bit set; combinational from registers only
module sync_filter_bank #(
    parameter int N = 4,
    parameter int STAGES = 2,
    parameter int FILT = 1,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] idata_i,
    output logic [N-1:0] odata_o,
    output logic [N-1:0] rise_o,
    output logic [N-1:0] fall_o,
    output logic         chg_o
);
    if (N < 1 || STAGES < 2 || FILT < 1) begin : g_bad_params
        $error("sync_filter_bank: requires N>=1, STAGES>=2, FILT>=1");
    end
    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CMAX = CW'(FILT - 1);
    logic [STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] odata_q, odata_d, rise_q, rise_d, fall_q, fall_d, s;
    assign s = sync_q[STAGES-1];
    // A differing value must persist FILT consecutive cycles at the chain output
    // before it is accepted; any return to the current level restarts the count.
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic upd;
        assign upd = (s[i] != odata_q[i]) && (cnt_q[i] == CMAX);
        assign cnt_d[i] = (s[i] == odata_q[i] || upd) ? '0 : cnt_q[i] + CW'(1);
        assign odata_d[i] = upd ? s[i] : odata_q[i];
        assign rise_d[i] = upd & s[i];
        assign fall_d[i] = upd & ~s[i];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            cnt_q <= '0;
            odata_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], idata_i};
            cnt_q <= cnt_d;
            odata_q <= odata_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign odata_o = odata_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o = |(rise_q | fall_q);
endmodule

// File: tb/tb_sync_filter_bank.sv
// tb_sync_filter_bank: three parameterisations checked against a windowed reference model
module tb_sync_filter_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] ia = '0, ib = '0;
    logic [7:0] ic = '0;
    logic [3:0] od_a, ri_a, fa_a, od_b, ri_b, fa_b;
    logic [7:0] od_c, ri_c, fa_c;
    logic ch_a, ch_b, ch_c;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    sync_filter_bank #(.N(4), .STAGES(2), .FILT(1), .RST_VAL(4'h0)) dut_a (
        .clk_i(clk), .rst_i(rst), .idata_i(ia),
        .odata_o(od_a), .rise_o(ri_a), .fall_o(fa_a), .chg_o(ch_a));
    sync_filter_bank #(.N(4), .STAGES(2), .FILT(4), .RST_VAL(4'h0)) dut_b (
        .clk_i(clk), .rst_i(rst), .idata_i(ib),
        .odata_o(od_b), .rise_o(ri_b), .fall_o(fa_b), .chg_o(ch_b));
    sync_filter_bank #(.N(8), .STAGES(3), .FILT(3), .RST_VAL(8'h00)) dut_c (
        .clk_i(clk), .rst_i(rst), .idata_i(ic),
        .odata_o(od_c), .rise_o(ri_c), .fall_o(fa_c), .chg_o(ch_c));
    int nn[3] = '{4, 4, 8};
    int ss[3] = '{2, 2, 3};
    int ff[3] = '{1, 4, 3};
    logic [7:0] d_od[3], d_ri[3], d_fa[3];
    logic d_ch[3];
    always_comb begin
        d_od[0] = {4'h0, od_a}; d_ri[0] = {4'h0, ri_a}; d_fa[0] = {4'h0, fa_a}; d_ch[0] = ch_a;
        d_od[1] = {4'h0, od_b}; d_ri[1] = {4'h0, ri_b}; d_fa[1] = {4'h0, fa_b}; d_ch[1] = ch_b;
        d_od[2] = od_c; d_ri[2] = ri_c; d_fa[2] = fa_c; d_ch[2] = ch_c;
    end
    logic [7:0] mp[3][3];
    logic [7:0] sh[3][4];
    int shn[3];
    logic [7:0] m_od[3], m_ri[3], m_fa[3];
    logic [7:0] pr[3] = '{8'h0, 8'h0, 8'h0};
    logic [7:0] pf[3] = '{8'h0, 8'h0, 8'h0};
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Reference: s is the input seen STAGES edges ago; a channel flips once the
    // last FILT values of s since reset all disagree with its current output.
    task automatic model(input int d, input logic [7:0] din);
        logic [7:0] s;
        bit all;
        if (rst) begin
            for (int k = 0; k < 3; k++) mp[d][k] = '0;
            shn[d] = 0;
            m_od[d] = '0;
            m_ri[d] = '0;
            m_fa[d] = '0;
        end else begin
            s = mp[d][ss[d]-1];
            for (int k = 2; k > 0; k--) mp[d][k] = mp[d][k-1];
            mp[d][0] = din;
            for (int j = 3; j > 0; j--) sh[d][j] = sh[d][j-1];
            sh[d][0] = s;
            if (shn[d] < 4) shn[d]++;
            m_ri[d] = '0;
            m_fa[d] = '0;
            for (int i = 0; i < nn[d]; i++) begin
                all = (shn[d] >= ff[d]);
                for (int j = 0; j < ff[d]; j++) if (sh[d][j][i] == m_od[d][i]) all = 0;
                if (all) begin
                    m_od[d][i] = ~m_od[d][i];
                    if (m_od[d][i]) m_ri[d][i] = 1'b1;
                    else m_fa[d][i] = 1'b1;
                end
            end
        end
    endtask
    task automatic step();
        @(posedge clk);
        model(0, {4'h0, ia});
        model(1, {4'h0, ib});
        model(2, ic);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("odata%0d", d), d_od[d], m_od[d]);
            chk($sformatf("rise%0d", d), d_ri[d], m_ri[d]);
            chk($sformatf("fall%0d", d), d_fa[d], m_fa[d]);
            chk($sformatf("chg%0d", d), {7'h0, d_ch[d]}, {7'h0, |(m_ri[d] | m_fa[d])});
            chk($sformatf("pulse_width%0d", d), (d_ri[d] & pr[d]) | (d_fa[d] & pf[d]), 8'h00);
            pr[d] = d_ri[d];
            pf[d] = d_fa[d];
        end
    endtask
    initial begin
        rst = 1'b1; ia = 4'hF; ib = 4'hF; ic = 8'hFF;
        repeat (3) begin
            step();
            chk("t1_rst_odata", d_od[0], 8'h00);
            chk("t1_rst_rise", d_ri[0], 8'h00);
            chk("t1_rst_fall", d_fa[0], 8'h00);
            chk("t1_rst_chg", {7'h0, d_ch[0]}, 8'h00);
        end
        rst = 1'b0;
        step();
        step();
        chk("t1_not_yet", d_od[0], 8'h00);
        step();
        chk("t1_rel_odata", d_od[0], 8'h0F);
        chk("t1_rel_rise", d_ri[0], 8'h0F);
        step();
        chk("t1_rel_rise_end", d_ri[0], 8'h00);
        ia = 4'h0;
        repeat (5) step();
        ia = 4'h5;
        step();
        step();
        chk("t2_not_yet", d_od[0], 8'h00);
        step();
        chk("t2_odata", d_od[0], 8'h05);
        chk("t2_rise", d_ri[0], 8'h05);
        chk("t2_chg", {7'h0, d_ch[0]}, 8'h01);
        step();
        chk("t2_rise_end", d_ri[0], 8'h00);
        chk("t2_chg_end", {7'h0, d_ch[0]}, 8'h00);
        ia = 4'h3;
        repeat (5) step();
        ia = 4'hC;
        repeat (3) step();
        chk("t4_rise", d_ri[0], 8'h0C);
        chk("t4_fall", d_fa[0], 8'h03);
        chk("t4_chg", {7'h0, d_ch[0]}, 8'h01);
        step();
        chk("t4_rise_end", d_ri[0], 8'h00);
        chk("t4_fall_end", d_fa[0], 8'h00);
        chk("t4_chg_end", {7'h0, d_ch[0]}, 8'h00);
        ib = 4'h0;
        repeat (10) step();
        ib = 4'h1;
        repeat (3) step();
        ib = 4'h0;
        repeat (8) begin
            step();
            chk("t3_short_odata", d_od[1], 8'h00);
            chk("t3_short_rise", d_ri[1], 8'h00);
        end
        ib = 4'h1;
        repeat (4) step();
        ib = 4'h0;
        step();
        chk("t3_not_yet", d_od[1], 8'h00);
        step();
        chk("t3_odata", d_od[1], 8'h01);
        chk("t3_rise", d_ri[1], 8'h01);
        step();
        chk("t3_rise_end", d_ri[1], 8'h00);
        repeat (2) step();
        step();
        chk("t3_fall", d_fa[1], 8'h01);
        chk("t3_fall_odata", d_od[1], 8'h00);
        repeat (3) step();
        ib = 4'h1;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("t5_rst_odata", d_od[1], 8'h00);
        chk("t5_rst_rise", d_ri[1], 8'h00);
        chk("t5_rst_fall", d_fa[1], 8'h00);
        rst = 1'b0;
        repeat (5) begin
            step();
            chk("t5_refilter_odata", d_od[1], 8'h00);
            chk("t5_refilter_rise", d_ri[1], 8'h00);
        end
        step();
        chk("t5_odata", d_od[1], 8'h01);
        chk("t5_rise", d_ri[1], 8'h01);
        repeat (600) begin
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(3) == 0) ia = 4'($urandom());
            if ($urandom_range(3) == 0) ib = 4'($urandom());
            if ($urandom_range(2) == 0) ic = 8'($urandom());
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
